// File: rtl/bascomp_pkg.sv
//==============================================================================
// Package : bascomp_pkg
// Shared types and constants for the basic-computer instruction sequencer.
// Revision: 1.0
//==============================================================================
`default_nettype none

package bascomp_pkg;

   localparam int SC_WIDTH_DEF  = 4;
   localparam int OPC_WIDTH_DEF = 3;

   // Opcode of the register-reference / IO group; its I bit never means indirect
   localparam logic [2:0] OPC_REG_IO = 3'b111;

   localparam int T0 = 0;
   localparam int T1 = 1;
   localparam int T2 = 2;
   localparam int T3 = 3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      DECODE   = 3'd2,
      INDIRECT = 3'd3,
      EXECUTE  = 3'd4,
      INTR     = 3'd5,
      HALT     = 3'd6
   } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_counter.sv
//==============================================================================
// Module : seq_counter
// Sequence counter with synchronous clear/increment and an all-ones flag.
// Revision: 1.0
//==============================================================================
`default_nettype none

module seq_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count,
   output logic             o_all_ones
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (i_clr)
         r_count <= '0;
      else if (i_inc)
         r_count <= r_count + WIDTH'(1);
   end

   assign o_count    = r_count;
   assign o_all_ones = &r_count;

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
//==============================================================================
// Module : instr_sequencer
// Instruction-cycle controller: SC, phase FSM, fetch/decode/indirect strobes.
// Optional interrupt cycle enabled by macro INSTR_SEQ_INTERRUPT_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module instr_sequencer
   import bascomp_pkg::*;
#(
   parameter int SC_WIDTH  = SC_WIDTH_DEF,
   parameter int OPC_WIDTH = OPC_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [OPC_WIDTH-1:0] ir_opcode,
   input  logic                 ir_i,
   input  logic                 sc_clr,
   input  logic                 halt_req,
   input  logic                 irq,
   input  logic                 ien,
   output logic [OPC_WIDTH-1:0] dec_sel,
   output logic [SC_WIDTH-1:0]  t_state,
   output logic                 ind,
   output logic                 running,
   output logic                 ar_from_pc,
   output logic                 ir_load,
   output logic                 pc_inc,
   output logic                 ar_from_ir,
   output logic                 ar_from_mem,
   output logic                 seq_err,
   output logic                 int_ack
);

   seq_state_t           r_state;
   seq_state_t           w_state_nxt;
   logic [OPC_WIDTH-1:0] r_dec_sel;
   logic                 r_ind;
   logic                 r_seq_err;
   logic                 w_sc_clr;
   logic                 w_sc_inc;
   logic                 w_sc_ones;
   logic                 w_err_set;
   logic                 w_dec_load;
   logic                 w_take_int;

   seq_counter #(.WIDTH(SC_WIDTH)) u_sc (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_sc_clr),
      .i_inc      (w_sc_inc),
      .o_count    (t_state),
      .o_all_ones (w_sc_ones)
   );

`ifdef INSTR_SEQ_INTERRUPT_EN
   logic r_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_r <= 1'b0;
      else if (r_state == INTR && t_state == SC_WIDTH'(T2))
         r_r <= 1'b0;
      else if (r_state == EXECUTE && sc_clr && !halt_req && ien && irq)
         r_r <= 1'b1;
   end

   assign w_take_int = r_r | (ien & irq);
`else
   logic w_unused_int;
   assign w_unused_int = irq ^ ien;
   assign w_take_int   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_dec_sel <= '0;
         r_ind     <= 1'b0;
         r_seq_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_dec_load) begin
            r_dec_sel <= ir_opcode;
            r_ind     <= ir_i;
         end
         if (w_err_set)
            r_seq_err <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sc_clr    = 1'b0;
      w_sc_inc    = 1'b0;
      w_err_set   = 1'b0;
      w_dec_load  = 1'b0;
      case (r_state)
         IDLE, HALT: begin
            if (start) begin
               w_state_nxt = FETCH;
               w_sc_clr    = 1'b1;
            end
         end
         FETCH: begin
            w_sc_inc = 1'b1;
            if (t_state == SC_WIDTH'(T1))
               w_state_nxt = DECODE;
         end
         DECODE: begin
            w_sc_inc   = 1'b1;
            w_dec_load = 1'b1;
            if (ir_opcode != OPC_WIDTH'(OPC_REG_IO) && ir_i)
               w_state_nxt = INDIRECT;
            else
               w_state_nxt = EXECUTE;
         end
         INDIRECT: begin
            w_sc_inc    = 1'b1;
            w_state_nxt = EXECUTE;
         end
         EXECUTE: begin
            if (sc_clr) begin
               w_sc_clr = 1'b1;
               if (halt_req)
                  w_state_nxt = HALT;
               else if (w_take_int)
                  w_state_nxt = INTR;
               else
                  w_state_nxt = FETCH;
            end else if (w_sc_ones) begin
               // Overflow parks SC at all-ones rather than wrapping into a bogus T0
               w_err_set   = 1'b1;
               w_state_nxt = HALT;
            end else begin
               w_sc_inc = 1'b1;
            end
         end
         INTR: begin
            if (t_state == SC_WIDTH'(T2)) begin
               w_sc_clr    = 1'b1;
               w_state_nxt = FETCH;
            end else begin
               w_sc_inc = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      running     = 1'b0;
      ar_from_pc  = 1'b0;
      ir_load     = 1'b0;
      pc_inc      = 1'b0;
      ar_from_ir  = 1'b0;
      ar_from_mem = 1'b0;
      int_ack     = 1'b0;
      case (r_state)
         FETCH: begin
            running    = 1'b1;
            ar_from_pc = (t_state == SC_WIDTH'(T0));
            ir_load    = (t_state == SC_WIDTH'(T1));
            pc_inc     = (t_state == SC_WIDTH'(T1));
         end
         DECODE: begin
            running    = 1'b1;
            ar_from_ir = (t_state == SC_WIDTH'(T2));
         end
         INDIRECT: begin
            running     = 1'b1;
            ar_from_mem = (t_state == SC_WIDTH'(T3));
         end
         EXECUTE: running = 1'b1;
         INTR: begin
            running = 1'b1;
            pc_inc  = (t_state == SC_WIDTH'(T2));
`ifdef INSTR_SEQ_INTERRUPT_EN
            int_ack = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   assign dec_sel = r_dec_sel;
   assign ind     = r_ind;
   assign seq_err = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
//==============================================================================
// Module : tb_instr_sequencer
// Directed scoreboard bench for instr_sequencer.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_instr_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] ir_opcode = 3'b000;
   logic       ir_i = 1'b0;
   logic       sc_clr = 1'b0;
   logic       halt_req = 1'b0;
   logic       irq = 1'b0;
   logic       ien = 1'b0;
   logic [2:0] dec_sel;
   logic [3:0] t_state;
   logic       ind, running, ar_from_pc, ir_load, pc_inc;
   logic       ar_from_ir, ar_from_mem, seq_err, int_ack;

   instr_sequencer #(.SC_WIDTH(4), .OPC_WIDTH(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .ir_opcode   (ir_opcode),
      .ir_i        (ir_i),
      .sc_clr      (sc_clr),
      .halt_req    (halt_req),
      .irq         (irq),
      .ien         (ien),
      .dec_sel     (dec_sel),
      .t_state     (t_state),
      .ind         (ind),
      .running     (running),
      .ar_from_pc  (ar_from_pc),
      .ir_load     (ir_load),
      .pc_inc      (pc_inc),
      .ar_from_ir  (ar_from_ir),
      .ar_from_mem (ar_from_mem),
      .seq_err     (seq_err),
      .int_ack     (int_ack)
   );

   always #5 clk = ~clk;

   // stb order: ar_from_pc, ir_load, pc_inc, ar_from_ir, ar_from_mem
   typedef struct packed {
      logic [3:0] t;
      logic [2:0] dec;
      logic       ind;
      logic       run;
      logic [4:0] stb;
      logic       err;
      logic       iack;
   } exp_t;

   localparam logic [4:0] S_NONE = 5'b00000;
   localparam logic [4:0] S_APC  = 5'b10000;
   localparam logic [4:0] S_T1   = 5'b01100;
   localparam logic [4:0] S_AIR  = 5'b00010;
   localparam logic [4:0] S_AMEM = 5'b00001;
   localparam logic [4:0] S_PCI  = 5'b00100;

   exp_t  expq[$];
   string tagq[$];
   int    vectors = 0;
   int    miscompares = 0;

   function automatic exp_t ex(input logic [3:0] t, input logic [2:0] d, input logic i,
                               input logic r, input logic [4:0] s, input logic er,
                               input logic ia);
      return {t, d, i, r, s, er, ia};
   endfunction

   task automatic check();
      exp_t  e;
      exp_t  o;
      string tag;
      e   = expq.pop_front();
      tag = tagq.pop_front();
      o   = {t_state, dec_sel, ind, running, ar_from_pc, ir_load, pc_inc,
             ar_from_ir, ar_from_mem, seq_err, int_ack};
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic cyc(input logic st, input logic clr, input logic hr,
                      input string tag, input exp_t e);
      start    = st;
      sc_clr   = clr;
      halt_req = hr;
      expq.push_back(e);
      tagq.push_back(tag);
      @(posedge clk);
      @(negedge clk);
      check();
   endtask

   initial begin
      expq.push_back(ex(0, 0, 0, 0, S_NONE, 0, 0));
      tagq.push_back("reset");
      @(negedge clk);
      check();
      rst_n = 1'b1;

      cyc(0, 1, 1, "idle_ignore", ex(0, 0, 0, 0, S_NONE, 0, 0));

      // Indirect memory-reference instruction
      ir_opcode = 3'b010; ir_i = 1'b1;
      cyc(1, 0, 0, "i1_t0",   ex(0, 3'b000, 0, 1, S_APC,  0, 0));
      cyc(0, 0, 0, "i1_t1",   ex(1, 3'b000, 0, 1, S_T1,   0, 0));
      cyc(0, 0, 0, "i1_t2",   ex(2, 3'b000, 0, 1, S_AIR,  0, 0));
      cyc(0, 0, 0, "i1_t3",   ex(3, 3'b010, 1, 1, S_AMEM, 0, 0));
      cyc(0, 0, 0, "i1_exec", ex(4, 3'b010, 1, 1, S_NONE, 0, 0));
      cyc(1, 1, 0, "i1_done", ex(0, 3'b010, 1, 1, S_APC,  0, 0));

      // Register/IO opcode: I bit does not cause an indirect cycle
      ir_opcode = 3'b111; ir_i = 1'b1;
      cyc(0, 0, 0, "i2_t1",   ex(1, 3'b010, 1, 1, S_T1,   0, 0));
      cyc(0, 0, 0, "i2_t2",   ex(2, 3'b010, 1, 1, S_AIR,  0, 0));
      cyc(0, 0, 0, "i2_exec", ex(3, 3'b111, 1, 1, S_NONE, 0, 0));
      cyc(0, 1, 0, "i2_done", ex(0, 3'b111, 1, 1, S_APC,  0, 0));

      // Halt together with sc_clr at T5
      ir_opcode = 3'b001; ir_i = 1'b0;
      cyc(0, 0, 0, "i3_t1",   ex(1, 3'b111, 1, 1, S_T1,   0, 0));
      cyc(0, 0, 0, "i3_t2",   ex(2, 3'b111, 1, 1, S_AIR,  0, 0));
      cyc(0, 0, 0, "i3_t3",   ex(3, 3'b001, 0, 1, S_NONE, 0, 0));
      cyc(0, 0, 0, "i3_t4",   ex(4, 3'b001, 0, 1, S_NONE, 0, 0));
      cyc(0, 0, 0, "i3_t5",   ex(5, 3'b001, 0, 1, S_NONE, 0, 0));
      cyc(0, 1, 1, "i3_halt", ex(0, 3'b001, 0, 0, S_NONE, 0, 0));
      cyc(0, 1, 0, "halt_ign",ex(0, 3'b001, 0, 0, S_NONE, 0, 0));
      cyc(1, 0, 0, "resume",  ex(0, 3'b001, 0, 1, S_APC,  0, 0));

      // sc_clr outside EXECUTE ignored, then SC overflow
      ir_opcode = 3'b011; ir_i = 1'b0;
      cyc(0, 1, 0, "i4_t1",   ex(1, 3'b001, 0, 1, S_T1,   0, 0));
      cyc(0, 1, 0, "i4_t2",   ex(2, 3'b001, 0, 1, S_AIR,  0, 0));
      cyc(0, 0, 0, "i4_t3",   ex(3, 3'b011, 0, 1, S_NONE, 0, 0));
      for (int k = 4; k < 16; k++)
         cyc(0, 0, 0, "i4_count", ex(4'(k), 3'b011, 0, 1, S_NONE, 0, 0));
      cyc(0, 0, 0, "overflow", ex(15, 3'b011, 0, 0, S_NONE, 1, 0));
      cyc(1, 0, 0, "err_t0",   ex(0, 3'b011, 0, 1, S_APC,  1, 0));
      cyc(0, 0, 0, "err_t1",   ex(1, 3'b011, 0, 1, S_T1,   1, 0));

      // Asynchronous reset in the middle of T1
      expq.push_back(ex(0, 0, 0, 0, S_NONE, 0, 0));
      tagq.push_back("async_rst");
      rst_n = 1'b0;
      #1;
      check();
      @(negedge clk);
      rst_n = 1'b1;

      // End of instruction with irq and ien asserted
      ir_opcode = 3'b111; ir_i = 1'b0;
      cyc(1, 0, 0, "i5_t0",   ex(0, 3'b000, 0, 1, S_APC,  0, 0));
      cyc(0, 0, 0, "i5_t1",   ex(1, 3'b000, 0, 1, S_T1,   0, 0));
      cyc(0, 0, 0, "i5_t2",   ex(2, 3'b000, 0, 1, S_AIR,  0, 0));
      cyc(0, 0, 0, "i5_t3",   ex(3, 3'b111, 0, 1, S_NONE, 0, 0));
      irq = 1'b1; ien = 1'b1;
`ifdef INSTR_SEQ_INTERRUPT_EN
      cyc(0, 1, 0, "int_rt0", ex(0, 3'b111, 0, 1, S_NONE, 0, 1));
      irq = 1'b0;
      cyc(0, 0, 0, "int_rt1", ex(1, 3'b111, 0, 1, S_NONE, 0, 1));
      cyc(0, 0, 0, "int_rt2", ex(2, 3'b111, 0, 1, S_PCI,  0, 1));
      cyc(0, 0, 0, "int_t0",  ex(0, 3'b111, 0, 1, S_APC,  0, 0));
`else
      cyc(0, 1, 0, "noint_t0", ex(0, 3'b111, 0, 1, S_APC, 0, 0));
      cyc(0, 0, 0, "noint_t1", ex(1, 3'b111, 0, 1, S_T1,  0, 0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
